// File: rtl/axi_lite_rd_arbiter.sv
// axi_lite_rd_arbiter: shares one AXI-lite read slave between fetch (M0)
// and LSU (M1); one grant at a time, held until its R handshake completes.
// Ports: clk, rst (sync, active-high); m0_*/m1_* AR+R master channels;
//   s_* AR+R slave channel; busy (not IDLE); grant_id (0=M0, 1=M1).
module axi_lite_rd_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 64,
  parameter bit RR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_araddr,
  input  logic          m0_arvalid,
  output logic          m0_arready,
  output logic [DW-1:0] m0_rdata,
  output logic [1:0]    m0_rresp,
  output logic          m0_rvalid,
  input  logic          m0_rready,
  input  logic [AW-1:0] m1_araddr,
  input  logic          m1_arvalid,
  output logic          m1_arready,
  output logic [DW-1:0] m1_rdata,
  output logic [1:0]    m1_rresp,
  output logic          m1_rvalid,
  input  logic          m1_rready,
  output logic [AW-1:0] s_araddr,
  output logic          s_arvalid,
  input  logic          s_arready,
  input  logic [DW-1:0] s_rdata,
  input  logic [1:0]    s_rresp,
  input  logic          s_rvalid,
  output logic          s_rready,
  output logic          busy,
  output logic          grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   grant_nxt;
  logic   rr_last;
  logic   rr_last_nxt;
  logic   pick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= 1'b0;
      rr_last  <= 1'b1;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      rr_last  <= rr_last_nxt;
    end
  end

  // Tie-break: in round-robin mode the master not served last wins;
  // otherwise the LSU always wins.
  always_comb begin
    pick = m1_arvalid;
    if (m0_arvalid && m1_arvalid) begin
      pick = RR_EN ? ~rr_last : 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_id;
    rr_last_nxt = rr_last;
    s_araddr    = '0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    m0_arready  = 1'b0;
    m1_arready  = 1'b0;
    m0_rvalid   = 1'b0;
    m1_rvalid   = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          grant_nxt = pick;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        s_araddr   = grant_id ? m1_araddr : m0_araddr;
        s_arvalid  = grant_id ? m1_arvalid : m0_arvalid;
        m0_arready = !grant_id && s_arready;
        m1_arready = grant_id && s_arready;
        if (s_arvalid && s_arready) begin
          state_nxt   = DATA;
          rr_last_nxt = grant_id;
        end
      end
      DATA: begin
        m0_rvalid = !grant_id && s_rvalid;
        m1_rvalid = grant_id && s_rvalid;
        s_rready  = grant_id ? m1_rready : m0_rready;
        if (s_rvalid && s_rready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is a plain broadcast; rvalid alone says who owns it.
  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// tb_axi_lite_rd_arbiter: round-robin and fixed-priority instances share
// stimulus; a transaction-level model predicts grants and data.
module tb_axi_lite_rd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] m0_araddr = '0, m1_araddr = '0;
  logic m0_arvalid = 1'b0, m1_arvalid = 1'b0;
  logic m0_rready = 1'b0, m1_rready = 1'b0;
  logic s_arready = 1'b0, s_rvalid = 1'b0;
  logic [63:0] s_rdata = '0;
  logic [1:0] s_rresp = '0;

  logic [1:0] o_m0_arready, o_m1_arready, o_m0_rvalid, o_m1_rvalid;
  logic [1:0] o_s_arvalid, o_s_rready, o_busy, o_grant;
  logic [63:0] o_m0_rdata[2], o_m1_rdata[2];
  logic [1:0] o_m0_rresp[2], o_m1_rresp[2];
  logic [31:0] o_s_araddr[2];

  always #5 clk = ~clk;

  axi_lite_rd_arbiter #(.AW(32), .DW(64), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid),
    .m0_arready(o_m0_arready[0]), .m0_rdata(o_m0_rdata[0]),
    .m0_rresp(o_m0_rresp[0]), .m0_rvalid(o_m0_rvalid[0]),
    .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid),
    .m1_arready(o_m1_arready[0]), .m1_rdata(o_m1_rdata[0]),
    .m1_rresp(o_m1_rresp[0]), .m1_rvalid(o_m1_rvalid[0]),
    .m1_rready(m1_rready),
    .s_araddr(o_s_araddr[0]), .s_arvalid(o_s_arvalid[0]),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rvalid(s_rvalid), .s_rready(o_s_rready[0]),
    .busy(o_busy[0]), .grant_id(o_grant[0])
  );

  axi_lite_rd_arbiter #(.AW(32), .DW(64), .RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid),
    .m0_arready(o_m0_arready[1]), .m0_rdata(o_m0_rdata[1]),
    .m0_rresp(o_m0_rresp[1]), .m0_rvalid(o_m0_rvalid[1]),
    .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid),
    .m1_arready(o_m1_arready[1]), .m1_rdata(o_m1_rdata[1]),
    .m1_rresp(o_m1_rresp[1]), .m1_rvalid(o_m1_rvalid[1]),
    .m1_rready(m1_rready),
    .s_araddr(o_s_araddr[1]), .s_arvalid(o_s_arvalid[1]),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rvalid(s_rvalid), .s_rready(o_s_rready[1]),
    .busy(o_busy[1]), .grant_id(o_grant[1])
  );

  // sel chooses which instance the slave/master models talk to
  logic sel = 1'b0;
  logic [1:0] xarready, xrvalid;
  logic [63:0] xrdata[2];
  logic [1:0] xrresp[2];

  always_comb begin
    xarready  = {o_m1_arready[sel], o_m0_arready[sel]};
    xrvalid   = {o_m1_rvalid[sel], o_m0_rvalid[sel]};
    xrdata[0] = o_m0_rdata[sel];
    xrdata[1] = o_m1_rdata[sel];
    xrresp[0] = o_m0_rresp[sel];
    xrresp[1] = o_m1_rresp[sel];
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bit p[2];
  logic [31:0] a[2];
  logic [31:0] base[2];
  int left[2], done[2], rrw[2], rv_cnt[2];
  int req_prob;
  bit rnd_addr;
  bit sl_has;
  logic [31:0] sl_addr;
  int ar_wait, r_wait, ar_cnt, r_cnt;
  bit use_fix;
  logic [63:0] fix_data;
  bit mb, addr_done;
  int own, mlast;
  logic [31:0] cur_addr;
  int grants[$], gcyc[$], rcyc[$];
  logic [63:0] rdat[$];
  logic [31:0] ar_log[$];

  function automatic logic [63:0] data_of(input logic [31:0] ad);
    return use_fix ? fix_data : {ad ^ 32'hdead_beef, ~ad};
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] ad);
    return use_fix ? 2'b00 : ad[4:3];
  endfunction

  task automatic step(input logic do_rst);
    logic [1:0] mrr;
    logic other;
    @(negedge clk);
    rst = do_rst;
    for (int i = 0; i < 2; i++) begin
      if (!p[i] && left[i] > 0 && $urandom_range(99) < req_prob) begin
        p[i] = 1'b1;
        left[i]--;
        a[i] = rnd_addr ? ($urandom & 32'hffff_fff8) : base[i];
      end
    end
    m0_arvalid = p[0];
    m0_araddr  = a[0];
    m1_arvalid = p[1];
    m1_araddr  = a[1];
    #1;
    s_arready = !sl_has && o_s_arvalid[sel] && ar_cnt >= ar_wait;
    s_rvalid  = sl_has && r_cnt >= r_wait;
    s_rdata   = data_of(sl_addr);
    s_rresp   = resp_of(sl_addr);
    #1;
    mrr[0] = xrvalid[0] && rv_cnt[0] >= rrw[0];
    mrr[1] = xrvalid[1] && rv_cnt[1] >= rrw[1];
    m0_rready = mrr[0];
    m1_rready = mrr[1];
    #1;
    other = ~own[0];
    if (!do_rst) begin
      total++;
      if (!mb) begin
        if ({o_busy[sel], o_s_arvalid[sel], o_s_rready[sel], xarready,
             xrvalid} !== 7'b0)
          begin
            bad++;
            $display("FAIL idle_out cyc=%0d got=%b%b%b%b%b need=0", cyc,
                     o_busy[sel], o_s_arvalid[sel], o_s_rready[sel],
                     xarready, xrvalid);
          end
      end else if ({o_busy[sel], o_grant[sel]} !== {1'b1, own[0]}) begin
        bad++;
        $display("FAIL owner cyc=%0d got=%b%b need=1%b", cyc,
                 o_busy[sel], o_grant[sel], own[0]);
      end
      if (mb && !addr_done) begin
        total++;
        if ({o_s_arvalid[sel], xarready[own], xarready[other], xrvalid,
             o_s_araddr[sel]} !== {p[own], s_arready, 1'b0, 2'b00, a[own]})
          begin
            bad++;
            $display("FAIL addr_ph cyc=%0d got=%b%b%b %h need=%b%b0 %h",
                     cyc, o_s_arvalid[sel], xarready[own],
                     xarready[other], o_s_araddr[sel], p[own], s_arready,
                     a[own]);
          end
      end
      if (mb && addr_done) begin
        total++;
        if ({xrvalid[own], xrvalid[other], o_s_rready[sel],
             o_s_arvalid[sel], xarready} !==
            {s_rvalid, 1'b0, mrr[own], 1'b0, 2'b00}) begin
          bad++;
          $display("FAIL data_ph cyc=%0d got=%b%b%b%b%b need=%b0%b000",
                   cyc, xrvalid[own], xrvalid[other], o_s_rready[sel],
                   o_s_arvalid[sel], xarready, s_rvalid, mrr[own]);
        end
        if (s_rvalid) begin
          total++;
          if ({xrdata[own], xrresp[own]} !==
              {data_of(cur_addr), resp_of(cur_addr)}) begin
            bad++;
            $display("FAIL rdata cyc=%0d got=%h/%0d need=%h/%0d", cyc,
                     xrdata[own], xrresp[own], data_of(cur_addr),
                     resp_of(cur_addr));
          end
        end
      end
    end
    if (do_rst) begin
      mb = 0;
      mlast = 1;
      sl_has = 0;
      ar_cnt = 0;
      r_cnt = 0;
      rv_cnt = '{0, 0};
    end else if (mb && !addr_done) begin
      if (p[own] && s_arready) begin
        addr_done = 1;
        cur_addr = a[own];
        ar_log.push_back(o_s_araddr[sel]);
        p[own] = 0;
        mlast = own;
        sl_has = 1;
        sl_addr = a[own];
        r_cnt = 0;
        ar_cnt = 0;
      end else if (o_s_arvalid[sel]) begin
        ar_cnt++;
      end
    end else if (mb) begin
      if (s_rvalid && mrr[own]) begin
        mb = 0;
        done[own]++;
        rcyc.push_back(cyc);
        rdat.push_back(xrdata[own]);
        sl_has = 0;
        rv_cnt[own] = 0;
      end else if (!s_rvalid) begin
        r_cnt++;
      end else begin
        rv_cnt[own]++;
      end
    end else if (p[0] || p[1]) begin
      if (p[0] && p[1]) own = sel ? 1 : (mlast == 1 ? 0 : 1);
      else own = p[1] ? 1 : 0;
      mb = 1;
      addr_done = 0;
      grants.push_back(own);
      gcyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic do_reset();
    p = '{0, 0};
    left = '{0, 0};
    done = '{0, 0};
    rrw = '{0, 0};
    base = '{32'h0, 32'h0};
    req_prob = 100;
    rnd_addr = 0;
    use_fix = 0;
    ar_wait = 0;
    r_wait = 0;
    sl_addr = '0;
    grants.delete();
    gcyc.delete();
    rcyc.delete();
    rdat.delete();
    ar_log.delete();
    step(1'b1);
    step(1'b1);
  endtask

  task automatic test_reset();
    sel = 0;
    do_reset();
    total++;
    if (o_grant[0] !== 1'b0 || o_grant[1] !== 1'b0) begin
      bad++;
      $display("FAIL rst_grant got=%b need=00", o_grant);
    end
    for (int n = 0; n < 10; n++) begin
      step(1'b0);
      total++;
      if ({o_busy, o_s_arvalid, o_s_rready, xarready, xrvalid} !== '0) begin
        bad++;
        $display("FAIL rst_idle n=%0d got=%b%b%b%b%b need=0", n, o_busy,
                 o_s_arvalid, o_s_rready, xarready, xrvalid);
      end
    end
  endtask

  task automatic test_single();
    sel = 0;
    do_reset();
    use_fix = 1;
    fix_data = 64'h00000013_00100093;
    base[0] = 32'h8000_0000;
    left[0] = 1;
    for (int n = 0; n < 20 && done[0] == 0; n++) step(1'b0);
    total++;
    if (done[0] != 1) begin
      bad++;
      $display("FAIL single_timeout got=%0d need=1", done[0]);
    end else begin
      total++;
      if (ar_log[0] !== 32'h8000_0000 || rdat[0] !== 64'h00000013_00100093)
        begin
          bad++;
          $display("FAIL single_xfer got=%h/%h need=80000000/%h",
                   ar_log[0], rdat[0], 64'h00000013_00100093);
        end
      total++;
      if (rcyc[0] - gcyc[0] != 2 || grants[0] != 0) begin
        bad++;
        $display("FAIL single_lat got=%0d g%0d need=2 g0",
                 rcyc[0] - gcyc[0], grants[0]);
      end
    end
    step(1'b0);
    total++;
    if (o_busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_busy got=%b need=0", o_busy[0]);
    end
  endtask

  task automatic test_rr();
    int exp_g[6] = '{0, 1, 0, 1, 0, 1};
    sel = 0;
    do_reset();
    base[0] = 32'h8000_0004;
    base[1] = 32'h8000_1000;
    left = '{3, 3};
    for (int n = 0; n < 60 && done[0] + done[1] < 6; n++) step(1'b0);
    total++;
    if (grants.size() != 6) begin
      bad++;
      $display("FAIL rr_count got=%0d need=6", grants.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        total++;
        if (grants[k] != exp_g[k]) begin
          bad++;
          $display("FAIL rr_seq k=%0d got=%0d need=%0d", k, grants[k],
                   exp_g[k]);
        end
        if (k > 0) begin
          total++;
          if (gcyc[k] - gcyc[k-1] != 3) begin
            bad++;
            $display("FAIL rr_b2b k=%0d got=%0d need=3", k,
                     gcyc[k] - gcyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_fixed();
    int exp_g[5] = '{1, 1, 1, 1, 0};
    sel = 1;
    do_reset();
    base[0] = 32'h8000_0004;
    base[1] = 32'h8000_1000;
    left = '{1, 4};
    for (int n = 0; n < 60 && done[0] + done[1] < 5; n++) step(1'b0);
    total++;
    if (grants.size() != 5) begin
      bad++;
      $display("FAIL fp_count got=%0d need=5", grants.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (grants[k] != exp_g[k]) begin
          bad++;
          $display("FAIL fp_seq k=%0d got=%0d need=%0d", k, grants[k],
                   exp_g[k]);
        end
      end
    end
  endtask

  task automatic test_stall();
    sel = 0;
    do_reset();
    ar_wait = 3;
    r_wait = 4;
    rrw[1] = 2;
    base[0] = 32'h8000_0008;
    base[1] = 32'h8000_1000;
    left[1] = 1;
    step(1'b0);
    left[0] = 1;
    for (int n = 0; n < 60 && done[0] + done[1] < 2; n++) step(1'b0);
    total++;
    if (grants.size() != 2 || rcyc.size() != 2) begin
      bad++;
      $display("FAIL stall_timeout got=%0d need=2", rcyc.size());
    end else begin
      total++;
      if (grants[0] != 1 || grants[1] != 0) begin
        bad++;
        $display("FAIL stall_order got=%0d,%0d need=1,0", grants[0],
                 grants[1]);
      end
      total++;
      if (rcyc[0] - gcyc[0] != 11 || gcyc[1] - rcyc[0] != 1) begin
        bad++;
        $display("FAIL stall_timing got=%0d/%0d need=11/1",
                 rcyc[0] - gcyc[0], gcyc[1] - rcyc[0]);
      end
      total++;
      if (rdat[0] !== data_of(32'h8000_1000)) begin
        bad++;
        $display("FAIL stall_data got=%h need=%h", rdat[0],
                 data_of(32'h8000_1000));
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    do_reset();
    base[0] = 32'h8000_0010;
    left[0] = 1;
    rrw[0] = 1000;
    for (int n = 0; n < 20 && !(mb && addr_done && s_rvalid); n++)
      step(1'b0);
    total++;
    if (xrvalid[0] !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre got=%b need=1", xrvalid[0]);
    end
    step(1'b1);
    @(negedge clk);
    rst = 1'b0;
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    s_rvalid = 1'b1;
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    #1;
    total++;
    if ({o_busy[0], o_s_arvalid[0], o_s_rready[0], xarready, xrvalid} !==
        7'b0) begin
      bad++;
      $display("FAIL mid_rst got=%b%b%b%b%b need=0", o_busy[0],
               o_s_arvalid[0], o_s_rready[0], xarready, xrvalid);
    end
    total++;
    if (done[0] + done[1] != 0) begin
      bad++;
      $display("FAIL mid_hs got=%0d need=0", done[0] + done[1]);
    end
    s_rvalid = 1'b0;
    do_reset();
  endtask

  task automatic test_random();
    int n0, n1;
    for (int it = 0; it < 6; it++) begin
      sel = 1'($urandom_range(1));
      do_reset();
      ar_wait = $urandom_range(3);
      r_wait = $urandom_range(3);
      rrw = '{$urandom_range(2), $urandom_range(2)};
      req_prob = 40;
      rnd_addr = 1;
      n0 = $urandom_range(8, 3);
      n1 = $urandom_range(8, 3);
      left = '{n0, n1};
      for (int n = 0; n < 600 &&
           !(left[0] == 0 && left[1] == 0 && !p[0] && !p[1] && !mb); n++)
        step(1'b0);
      total++;
      if (done[0] != n0 || done[1] != n1) begin
        bad++;
        $display("FAIL rand_done it=%0d got=%0d/%0d need=%0d/%0d", it,
                 done[0], done[1], n0, n1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_fixed();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_rd_arbiter.md
Name: axi_lite_rd_arbiter

Overview:
- Shares one AXI-lite read slave (the instruction/data memory slave) between two read masters: M0 = instruction fetch unit, M1 = load/store unit.
- Sits between the fetch/LSU read state machines and the single memory slave.
- Grants one master at a time and holds the grant until that master's R handshake completes.
- Supports fixed-priority or round-robin arbitration.

Parameters:
- AW, 32, address width
- DW, 64, read data width
- RR_EN, 1, 1 = round-robin between M0/M1; 0 = fixed priority, M1 (LSU) wins ties

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_araddr  in  AW  fetch read address
- m0_arvalid  in  1  fetch address valid
- m0_arready  out  1  fetch address accepted
- m0_rdata  out  DW  fetch read data
- m0_rresp  out  2  fetch read response
- m0_rvalid  out  1  fetch data valid
- m0_rready  in  1  fetch data ready
- m1_araddr, m1_arvalid, m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_rready  same as M0, for LSU
- s_araddr  out  AW  to slave
- s_arvalid  out  1  to slave
- s_arready  in  1  from slave
- s_rdata  in  DW  from slave
- s_rresp  in  2  from slave
- s_rvalid  in  1  from slave
- s_rready  out  1  to slave
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  registered owner, 0 = M0, 1 = M1; valid while busy

Behaviour:
- Reset: state = IDLE, grant_id = 0, rr_last = 1 (so M0 wins the first tie in RR mode).
- Reset outputs: all m*_arready, m*_rvalid, s_arvalid and s_rready are 0; busy = 0.
- Data outputs: m*_rdata and m*_rresp are forwarded combinationally from the slave; they are meaningful only when the matching rvalid = 1.
- States: IDLE, ADDR, DATA.
- IDLE:
  - No slave signals are driven active.
  - Arbitration happens on a clock edge where either arvalid is high:
    - only one arvalid high: grant that master;
    - both high with RR_EN=1: grant the master that is not rr_last;
    - both high with RR_EN=0: grant M1.
  - grant_id is registered; next state is ADDR.
  - Arbitration latency is 1 cycle; no AR handshake happens in the IDLE cycle.
- ADDR:
  - s_araddr = granted araddr; s_arvalid = granted arvalid; granted arready = s_arready.
  - The non-granted arready is 0.
  - On s_arvalid & s_arready: go to DATA, and set rr_last = grant_id.
- DATA:
  - Granted rvalid = s_rvalid; granted rdata/rresp = s_rdata/s_rresp; s_rready = granted rready.
  - The non-granted rvalid is 0.
  - On s_rvalid & s_rready: go to IDLE.
- Back-to-back: after a DATA handshake, the arbiter spends one IDLE cycle before the next grant. Minimum turnaround is IDLE -> ADDR -> DATA, i.e. 3 cycles per transfer with a zero-wait slave.
- Non-granted master: its arvalid may stay high indefinitely. It is never acknowledged until granted, and its request is not lost.
- Round-robin guarantee: with both masters continuously requesting, grants alternate M0, M1, M0, ...
- Fixed priority: M0 can starve; this is intended.
- Granted master deasserts arvalid in ADDR (AXI violation): arbiter remains in ADDR with s_arvalid = 0. There is no timeout.
- Granted master holds rready low in DATA: arbiter stays in DATA. The slave must hold its data, per AXI.
- Reset mid-transaction: return to IDLE next edge with all handshake outputs 0. The slave shares rst, so no stale response is forwarded.
- Single outstanding transaction only; no ID tagging. Write channels are outside this block.
- Widths: pure pass-through, no arithmetic.

Test Plan:
- Reset, no requests -> busy=0, s_arvalid=0, m0/m1 arready=0, m0/m1 rvalid=0 for 10 cycles.
- Single M0 request, araddr=0x80000000, zero-wait slave returns rdata=0x00000013_00100093, rresp=0:
  - required: s_araddr=0x80000000 in ADDR;
  - m0 sees rvalid with that data exactly 2 cycles after the grant edge;
  - m1 rvalid stays 0; busy drops after the R handshake.
- Simultaneous M0 (0x80000004) and M1 (0x80001000), RR_EN=1, after reset:
  - M0 is granted first, then M1;
  - repeating for 6 transfers gives grant_id sequence 0,1,0,1,0,1.
- Same stimulus with RR_EN=0 -> all grants go to M1 while it keeps requesting; M0 is granted only when m1_arvalid=0.
- Slave stalls arready for 3 cycles and rvalid for 4 cycles; M1 holds rready=0 for 2 cycles after rvalid:
  - state holds in ADDR and DATA accordingly;
  - data is delivered unchanged;
  - M0's pending request is granted on the edge after M1's IDLE cycle.
- Assert rst while in DATA with s_rvalid=1 -> next cycle state=IDLE, busy=0, m*_rvalid=0; no handshake is completed to either master.
